// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode/state types and helpers for the ALU arbiter
// Contents:
//   ALU_W        default operand/result width
//   alu_op_t     legal ALU opcodes (011 and 111 are unused encodings)
//   arb_state_t  arbiter FSM states
//   is_legal_op  1 when an opcode is one the ALU implements
package alu_pkg;

  localparam int ALU_W = 32;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b110,
    OP_SHL = 3'b100,
    OP_SHR = 3'b101
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    EXEC,
    RESP
  } arb_state_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SHL, OP_SHR: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester-side request/response bundle of the ALU arbiter
// Signals:
//   req_valid/req_ready  per-requester operation handshake (ready is one-hot)
//   req_op/req_a/req_b   per-requester opcode and operands
//   rsp_valid/rsp_ready  per-requester response handshake (valid is one-hot)
//   rsp_result           shared result bus
//   rsp_zero/rsp_overflow/rsp_err  shared response flags
// Modports: master = requesters, slave = arbiter.
interface alu_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = alu_pkg::ALU_W
);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0][2:0]   req_op;
  logic [NREQ-1:0][W-1:0] req_a;
  logic [NREQ-1:0][W-1:0] req_b;
  logic [NREQ-1:0]        rsp_valid;
  logic [NREQ-1:0]        rsp_ready;
  logic [W-1:0]           rsp_result;
  logic                   rsp_zero;
  logic                   rsp_overflow;
  logic                   rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_overflow, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_overflow, rsp_err
  );

endinterface

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin priority select
// Ports:
//   valid  in   NREQ  request vector
//   ptr    in   IW    last granted index; search starts at ptr+1 and wraps
//   grant  out  NREQ  one-hot winner (all zero when nothing valid)
//   idx    out  IW    winner index
//   any    out  1     at least one request valid
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  always_comb begin
    logic [IW-1:0] cand;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    // Walk ptr+1 .. ptr+NREQ; the last candidate is ptr itself, so the
    // previous winner has lowest priority.
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (!any && valid[cand]) begin
        any         = 1'b1;
        idx         = cand;
        grant       = '0;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one ALU between NREQ requesters
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   bus            alu_arbiter_if.slave request/response bundle
//   alu_op         opcode held on the ALU
//   alu_a, alu_b   operands held on the ALU
//   alu_result     ALU result (registered inside the ALU, ALU_LAT edges)
//   alu_overflow   ALU overflow flag
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int ALU_LAT = 1,
  parameter int W       = ALU_W
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus,
  output logic [2:0]    alu_op,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  input  logic [W-1:0]  alu_result,
  input  logic          alu_overflow
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(ALU_LAT + 2);
  // EXEC lasts ALU_LAT+1 edges: ALU_LAT for the ALU plus one for its output register.
  localparam logic [CW-1:0] EXEC_LAST = CW'(ALU_LAT);

  arb_state_t      state_q, state_d;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   win_q;
  logic [NREQ-1:0] win_oh_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    res_q;
  logic            zero_q, ovf_q, err_q;

  logic [IW-1:0]   pick_idx;
  logic [NREQ-1:0] pick_grant;
  logic            pick_any;
  logic            accept;
  logic            win_legal;

  rr_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
    .valid (bus.req_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // The winner may withdraw between IDLE and GRANT; only a still-valid winner is accepted.
  assign accept    = (state_q == GRANT) && bus.req_valid[win_q];
  assign win_legal = is_legal_op(bus.req_op[win_q]);

  assign bus.rsp_result   = res_q;
  assign bus.rsp_zero     = zero_q;
  assign bus.rsp_overflow = ovf_q;
  assign bus.rsp_err      = err_q;

  always_comb begin
    state_d       = state_q;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    case (state_q)
      IDLE: begin
        if (pick_any) state_d = GRANT;
      end
      GRANT: begin
        if (accept) begin
          bus.req_ready = win_oh_q;
          state_d       = win_legal ? EXEC : RESP;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        if (cnt_q == EXEC_LAST) state_d = RESP;
      end
      RESP: begin
        bus.rsp_valid = win_oh_q;
        if (bus.rsp_ready[win_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= IW'(NREQ - 1);
      win_q    <= '0;
      win_oh_q <= '0;
      cnt_q    <= '0;
      alu_op   <= 3'b000;
      alu_a    <= '0;
      alu_b    <= '0;
      res_q    <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            win_q    <= pick_idx;
            win_oh_q <= pick_grant;
          end
        end
        GRANT: begin
          if (accept) begin
            alu_op <= bus.req_op[win_q];
            alu_a  <= bus.req_a[win_q];
            alu_b  <= bus.req_b[win_q];
            ptr_q  <= win_q;
            cnt_q  <= '0;
            // Illegal opcodes never reach the ALU result path.
            if (!win_legal) begin
              res_q  <= '0;
              zero_q <= 1'b1;
              ovf_q  <= 1'b0;
              err_q  <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (cnt_q == EXEC_LAST) begin
            res_q  <= alu_result;
            zero_q <= (alu_result == '0);
            ovf_q  <= alu_overflow;
            err_q  <= 1'b0;
            cnt_q  <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
